accum_stream_monitor: RTL and testbench
=======================================

Name: accum_stream_monitor

Overview:
- Runtime checker sitting directly downstream of the selector-gated accumulator (x <= x + y, y <= y + 1 while selector && y < LIMIT; x/y reset to 1/0).
- Consumes the accumulator's registered x/y outputs every cycle and verifies the update relation, the LIMIT ceiling and the post-limit invariant (x >= y).
- Produces a sticky error with a first-fault code, a done flag and activity counters for the property-mining bench and for on-line checking.

Parameters:
W, 15, width of x and y buses
LIMIT, 200, y ceiling of the upstream accumulator
CW, 16, width of step/stall counters

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high; same reset as upstream accumulator
x  input  W  accumulator x output
y  input  W  accumulator y output
err  output  1  sticky fault flag
err_code  output  3  first fault code (0 = none)
fail_y  output  W  y value sampled at first fault
done  output  1  sticky; y == LIMIT observed with no fault
step_cnt  output  CW  number of valid advances observed, saturating
stall_cnt  output  CW  number of hold cycles observed in TRACK, saturating

Behaviour:
- Reset values: err=0, err_code=0, fail_y=0, done=0, step_cnt=0, stall_cnt=0, state=INIT, prev_x=0, prev_y=0. Reset dominates and is legal in any state, including FAIL.
- All outputs are registered. A fault on the x/y present before edge N is reported (err=1) after edge N, i.e. one-cycle latency.
- States: INIT, TRACK, DONE, FAIL.
- INIT, first edge with rst=0:
  - requires x==1 && y==0, else FAIL with code 1 (BAD_INIT).
  - Capture prev_x=x, prev_y=y, then go to TRACK.
- TRACK, checks each edge in priority order, first match wins. All arithmetic is mod 2^W.
  - code 5 OVER_LIMIT: y > LIMIT.
  - code 4 BAD_JUMP: y != prev_y && y != prev_y+1.
  - code 2 BAD_HOLD: y == prev_y && x != prev_x.
  - code 3 BAD_STEP: y == prev_y+1 && x != prev_x+prev_y.
  - code 6 INV: y >= LIMIT && x < y.
- TRACK, no fault:
  - Advance (y == prev_y+1): step_cnt+1.
  - Hold: stall_cnt+1.
  - Update prev_x, prev_y.
  - If y == LIMIT, set done=1 and go to DONE. Done and the step count update on the same edge.
- DONE:
  - Any change of x or y: FAIL with code 4 if y changed, else code 2. done stays 1.
  - Holding does not increment stall_cnt.
- FAIL:
  - Terminal until rst. err=1; err_code and fail_y latched at the entering edge and frozen.
  - Counters frozen.
  - A later fault never overwrites the code.
- Counters saturate at 2^CW-1 and do not wrap.
- Width rule: with the defaults, the maximum legal x is 1 + LIMIT*(LIMIT-1)/2 = 19901, which fits in W. No overflow is expected in a legal stream. A wrapped value surfaces as BAD_STEP or INV.
- If rst is deasserted for only one cycle and reasserted, the block returns to INIT. No partial state is retained.

Test Plan:
- Legal run: drive the accumulator-exact sequence with selector always 1 → after 200 advances y=200, x=19901; next cycle done=1, step_cnt=200, err=0, stall_cnt=0.
- Bad init: first post-reset sample x=2, y=0 → next cycle err=1, err_code=1, fail_y=0; counters 0.
- Bad step: legal x/y 1/0, 1/1, 2/2, 4/3, then x=8, y=4 (expected 7) → err_code=3, fail_y=4, step_cnt=3.
- Holds and jump:
  - Hold at x=4, y=3 for 5 cycles → stall_cnt=5, err=0.
  - Then x=10, y=5 → err_code=4.
  - Then x=0, y=300 → err_code stays 4.
- Post-done disturbance: after done=1, change x to 19900 with y=200 → err_code=2, done stays 1.
- Reset mid-FAIL: assert rst for 1 cycle after any fault → err=0, err_code=0, counters=0, state INIT; a legal run afterwards passes.

Source files
------------

// File: rtl/accum_stream_monitor.sv
// On-line checker for the selector-gated accumulator stream (x <= x + y, y <= y + 1 up to LIMIT).
// Flags the first fault with a sticky code and the y value seen at that point, and counts advances and holds.
module accum_stream_monitor #(
    parameter int W     = 15,
    parameter int LIMIT = 200,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [W-1:0]  fail_y,
    output logic          done,
    output logic [CW-1:0] step_cnt,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {S_INIT, S_TRACK, S_DONE, S_FAIL} state_t;

    localparam logic [2:0] C_NONE       = 3'd0;
    localparam logic [2:0] C_BAD_INIT   = 3'd1;
    localparam logic [2:0] C_BAD_HOLD   = 3'd2;
    localparam logic [2:0] C_BAD_STEP   = 3'd3;
    localparam logic [2:0] C_BAD_JUMP   = 3'd4;
    localparam logic [2:0] C_OVER_LIMIT = 3'd5;
    localparam logic [2:0] C_INV        = 3'd6;

    localparam logic [W-1:0]  LIM     = W'(LIMIT);
    localparam logic [W-1:0]  ONE     = W'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t         state, state_nx;
    logic [W-1:0]   prev_x, prev_y;
    logic [W-1:0]   y_inc, x_sum;
    logic [2:0]     code_nx;
    logic           cap, adv, hold;

    // Wrapping sums are intentional: an overflowed x shows up as BAD_STEP/INV
    assign y_inc = prev_y + ONE;
    assign x_sum = prev_x + prev_y;

    always_comb begin
        state_nx = state;
        code_nx  = C_NONE;
        cap      = 1'b0;
        adv      = 1'b0;
        hold     = 1'b0;
        case (state)
            S_INIT: begin
                if (x == ONE && y == '0) begin
                    cap      = 1'b1;
                    state_nx = S_TRACK;
                end else begin
                    code_nx = C_BAD_INIT;
                end
            end
            S_TRACK: begin
                if (y > LIM)                               code_nx = C_OVER_LIMIT;
                else if (y != prev_y && y != y_inc)        code_nx = C_BAD_JUMP;
                else if (y == prev_y && x != prev_x)       code_nx = C_BAD_HOLD;
                else if (y == y_inc && x != x_sum)         code_nx = C_BAD_STEP;
                else if (y >= LIM && x < y)                code_nx = C_INV;
                else begin
                    cap  = 1'b1;
                    adv  = (y == y_inc);
                    hold = (y != y_inc);
                    if (y == LIM) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (y != prev_y)      code_nx = C_BAD_JUMP;
                else if (x != prev_x) code_nx = C_BAD_HOLD;
            end
            default: ;
        endcase
        if (code_nx != C_NONE) state_nx = S_FAIL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            prev_x    <= '0;
            prev_y    <= '0;
            err       <= 1'b0;
            err_code  <= C_NONE;
            fail_y    <= '0;
            done      <= 1'b0;
            step_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cap) begin
                prev_x <= x;
                prev_y <= y;
            end
            // code_nx is only non-zero outside FAIL, so the first code is never overwritten
            if (code_nx != C_NONE) begin
                err      <= 1'b1;
                err_code <= code_nx;
                fail_y   <= y;
            end
            if (state == S_TRACK && state_nx == S_DONE) done <= 1'b1;
            if (adv && step_cnt != CNT_MAX)   step_cnt  <= step_cnt + CW'(1);
            if (hold && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_accum_stream_monitor.sv
// Bench for accum_stream_monitor: directed scenarios plus random accumulator streams with
// injected corruptions, all compared every cycle against a behavioural model of the checker rules.
module tb_accum_stream_monitor;

    localparam int W     = 15;
    localparam int LIMIT = 200;
    localparam int CW    = 16;
    localparam int MOD   = 1 << W;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          err;
    logic [2:0]    err_code;
    logic [W-1:0]  fail_y;
    logic          done;
    logic [CW-1:0] step_cnt;
    logic [CW-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    accum_stream_monitor #(.W(W), .LIMIT(LIMIT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .err(err), .err_code(err_code), .fail_y(fail_y), .done(done),
        .step_cnt(step_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 = waiting for first sample, 1 = following the stream,
    // 2 = finished at LIMIT, 3 = faulted.
    int m_phase, m_px, m_py, m_err, m_code, m_fy, m_done, m_step, m_stall;

    // Upstream accumulator used to produce legal traffic
    int ax, ay;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_fault(input int code, input int yv);
        m_phase = 3;
        m_err   = 1;
        m_code  = code;
        m_fy    = yv;
    endfunction

    function automatic void m_apply(input bit r, input int xv, input int yv);
        int want_y, want_x, code;
        bit stepped, held;
        if (r) begin
            m_phase = 0; m_px = 0; m_py = 0; m_err = 0; m_code = 0;
            m_fy = 0; m_done = 0; m_step = 0; m_stall = 0;
            return;
        end
        if (m_phase == 0) begin
            if (xv == 1 && yv == 0) begin
                m_phase = 1; m_px = xv; m_py = yv;
            end else m_fault(1, yv);
        end else if (m_phase == 1) begin
            want_y  = (m_py + 1) % MOD;
            want_x  = (m_px + m_py) % MOD;
            stepped = (yv == want_y);
            held    = (yv == m_py);
            if (yv > LIMIT)                    code = 5;
            else if (!stepped && !held)        code = 4;
            else if (held && xv != m_px)       code = 2;
            else if (stepped && xv != want_x)  code = 3;
            else if (yv >= LIMIT && xv < yv)   code = 6;
            else                               code = 0;
            if (code != 0) m_fault(code, yv);
            else begin
                if (stepped) m_step  = (m_step  < CMAX) ? m_step + 1  : CMAX;
                else         m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                m_px = xv; m_py = yv;
                if (yv == LIMIT) begin
                    m_phase = 2; m_done = 1;
                end
            end
        end else if (m_phase == 2) begin
            if (yv != m_py)      m_fault(4, yv);
            else if (xv != m_px) m_fault(2, yv);
        end
    endfunction

    task automatic cyc(input bit r, input int xv, input int yv);
        int xm, ym;
        xm = xv % MOD; ym = yv % MOD;
        rst = r;
        x   = xm[W-1:0];
        y   = ym[W-1:0];
        @(posedge clk);
        m_apply(r, xm, ym);
        #1;
        chk("err",       err,       m_err);
        chk("err_code",  err_code,  m_code);
        chk("fail_y",    fail_y,    m_fy);
        chk("done",      done,      m_done);
        chk("step_cnt",  step_cnt,  m_step);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic acc_reset();
        ax = 1; ay = 0;
    endtask

    task automatic acc_step(input bit sel);
        if (sel && ay < LIMIT) begin
            ax = ax + ay;
            ay = ay + 1;
        end
    endtask

    initial begin
        m_apply(1'b1, 0, 0);

        // Reset state
        cyc(1, 0, 0);
        cyc(1, 5, 7);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_done", done, 0);
        chk("rst_steps", step_cnt, 0);

        // Full legal run with selector held high
        acc_reset();
        cyc(0, ax, ay);
        for (int i = 0; i < LIMIT; i++) begin
            acc_step(1'b1);
            cyc(0, ax, ay);
        end
        chk("legal_done", done, 1);
        chk("legal_steps", step_cnt, 200);
        chk("legal_stalls", stall_cnt, 0);
        chk("legal_err", err, 0);
        cyc(0, 19901, 200);
        chk("done_hold_stalls", stall_cnt, 0);
        chk("done_hold_err", err, 0);

        // Disturbance after done
        cyc(0, 19900, 200);
        chk("postdone_code", err_code, 2);
        chk("postdone_done", done, 1);
        chk("postdone_fy", fail_y, 200);

        // Single-cycle reset from FAIL, then bad init
        cyc(1, 0, 0);
        chk("rstfail_err", err, 0);
        chk("rstfail_code", err_code, 0);
        chk("rstfail_steps", step_cnt, 0);
        cyc(0, 2, 0);
        chk("badinit_code", err_code, 1);
        chk("badinit_fy", fail_y, 0);
        chk("badinit_steps", step_cnt, 0);

        // Bad step
        cyc(1, 0, 0);
        cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 2, 2); cyc(0, 4, 3);
        cyc(0, 8, 4);
        chk("badstep_code", err_code, 3);
        chk("badstep_fy", fail_y, 4);
        chk("badstep_steps", step_cnt, 3);

        // Holds, then a jump, then a later fault that must not overwrite
        cyc(1, 0, 0);
        cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 2, 2); cyc(0, 4, 3);
        for (int i = 0; i < 5; i++) cyc(0, 4, 3);
        chk("hold_stalls", stall_cnt, 5);
        chk("hold_err", err, 0);
        cyc(0, 10, 5);
        chk("jump_code", err_code, 4);
        cyc(0, 0, 300);
        chk("sticky_code", err_code, 4);
        chk("sticky_fy", fail_y, 5);

        // Legal run after reset from FAIL
        cyc(1, 0, 0);
        acc_reset();
        cyc(0, ax, ay);
        for (int i = 0; i < LIMIT; i++) begin
            acc_step(1'b1);
            cyc(0, ax, ay);
        end
        chk("rerun_done", done, 1);
        chk("rerun_err", err, 0);

        // Random streams: selector density, fault injection and mid-run resets vary per run
        for (int run = 0; run < 24; run++) begin
            int dens, len, fault_at, kind, rst_at, xv, yv;
            cyc(1, 0, 0);
            acc_reset();
            dens     = $urandom_range(100, 40);
            len      = $urandom_range(420, 60);
            fault_at = ($urandom_range(1, 0) == 1) ? $urandom_range(len - 1, 0) : -1;
            rst_at   = ($urandom_range(5, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            for (int c = 0; c < len; c++) begin
                if (c > 0) acc_step($urandom_range(99, 0) < dens);
                xv = ax; yv = ay;
                if (c == fault_at) begin
                    kind = $urandom_range(5, 0);
                    case (kind)
                        0: xv = ax ^ (1 << $urandom_range(W - 1, 0));
                        1: yv = ay + $urandom_range(5, 2);
                        2: yv = LIMIT + $urandom_range(50, 1);
                        3: xv = ax + 1;
                        4: begin xv = $urandom_range(MOD - 1, 0); yv = $urandom_range(MOD - 1, 0); end
                        default: xv = (ay >= LIMIT) ? LIMIT - 1 : ax + 3;
                    endcase
                end
                if (c == rst_at) begin
                    cyc(1, xv, yv);
                    acc_reset();
                end else cyc(0, xv, yv);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
